vga_sync_gen: RTL and testbench



---
 rtl/vga_timing_pkg.sv | 16 +
 rtl/vga_sync_gen_pixel_tick_gen.sv | 17 +
 rtl/vga_sync_gen.sv | 69 ++++++
 tb/tb_vga_sync_gen.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480@60 timing, sync polarity and coordinate width
package vga_timing_pkg;
  localparam int CLK_DIV = 4;
  localparam int H_DISPLAY = 640;
  localparam int H_FRONT = 16;
  localparam int H_SYNC = 96;
  localparam int H_BACK = 48;
  localparam int V_DISPLAY = 480;
  localparam int V_FRONT = 10;
  localparam int V_SYNC = 2;
  localparam int V_BACK = 33;
  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam logic SYNC_ACTIVE = 1'b0;
  localparam int COORD_W = 10;
endpackage

// File: rtl/vga_sync_gen_pixel_tick_gen.sv
// pixel_tick_gen: divides clk by CLK_DIV into a one-clk pixel enable
module pixel_tick_gen #(
  parameter int CLK_DIV = vga_timing_pkg::CLK_DIV
) (
  input  logic clk,
  input  logic reset,
  output logic p_tick
);
  localparam int W = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);
  logic [W-1:0] div_cnt;
  // free-running divider, wraps after the last count of each pixel
  always_ff @(posedge clk or posedge reset)
    if (reset) div_cnt <= '0;
    else div_cnt <= p_tick ? '0 : div_cnt + 1'b1;
  assign p_tick = div_cnt == LAST;
endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA pixel enable, x/y counters, sync pulses, video_on, frame_tick; VGA_FRAME_COUNT_EN adds frame_cnt
module vga_sync_gen #(
  parameter int CLK_DIV = vga_timing_pkg::CLK_DIV,
  parameter int H_DISPLAY = vga_timing_pkg::H_DISPLAY,
  parameter int H_FRONT = vga_timing_pkg::H_FRONT,
  parameter int H_SYNC = vga_timing_pkg::H_SYNC,
  parameter int H_BACK = vga_timing_pkg::H_BACK,
  parameter int V_DISPLAY = vga_timing_pkg::V_DISPLAY,
  parameter int V_FRONT = vga_timing_pkg::V_FRONT,
  parameter int V_SYNC = vga_timing_pkg::V_SYNC,
  parameter int V_BACK = vga_timing_pkg::V_BACK
) (
  input  logic clk,
  input  logic reset,
  output logic p_tick,
  output logic [vga_timing_pkg::COORD_W-1:0] x,
  output logic [vga_timing_pkg::COORD_W-1:0] y,
  output logic hsync,
  output logic vsync,
  output logic video_on,
  output logic frame_tick
`ifdef VGA_FRAME_COUNT_EN
  , output logic [7:0] frame_cnt
`endif
);
  localparam logic SYNC_ACTIVE = vga_timing_pkg::SYNC_ACTIVE;
  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  typedef logic [vga_timing_pkg::COORD_W-1:0] coord_t;
  localparam coord_t H_LAST = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST = coord_t'(V_TOTAL - 1);
  localparam coord_t H_VIS = coord_t'(H_DISPLAY);
  localparam coord_t V_VIS = coord_t'(V_DISPLAY);
  localparam coord_t HS_START = coord_t'(H_DISPLAY + H_FRONT);
  localparam coord_t HS_END = coord_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam coord_t VS_START = coord_t'(V_DISPLAY + V_FRONT);
  localparam coord_t VS_END = coord_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);
  logic h_end, v_end;
  coord_t h_next, v_next;
  pixel_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (.clk(clk), .reset(reset), .p_tick(p_tick));
  // next counter values; syncs are decoded from these so they line up with x/y
  always_comb begin
    h_end = x == H_LAST;
    v_end = y == V_LAST;
    h_next = p_tick ? (h_end ? '0 : x + 1'b1) : x;
    v_next = (p_tick && h_end) ? (v_end ? '0 : y + 1'b1) : y;
  end
  // coordinate and sync registers
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      x <= '0;
      y <= '0;
      hsync <= ~SYNC_ACTIVE;
      vsync <= ~SYNC_ACTIVE;
    end else begin
      x <= h_next;
      y <= v_next;
      hsync <= (h_next >= HS_START && h_next <= HS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vsync <= (v_next >= VS_START && v_next <= VS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    end
  assign video_on = x < H_VIS && y < V_VIS;
  assign frame_tick = p_tick & h_end & v_end;
`ifdef VGA_FRAME_COUNT_EN
  // frame counter, advances on each frame_tick and wraps naturally
  always_ff @(posedge clk or posedge reset)
    if (reset) frame_cnt <= '0;
    else if (frame_tick) frame_cnt <= frame_cnt + 1'b1;
`endif
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: directed checks of vga_sync_gen at full and reduced timing
`define CHK(t, o, e) begin checks++; assert ((o) === (e)) else begin errors++; $error("FAIL %s observed=%0d expected=%0d", t, o, e); end end
module tb_vga_sync_gen;
  logic clk = 0, rst_d = 1, rst_s = 1;
  logic pt_d, hs_d, vs_d, vo_d, ft_d, pt_s, hs_s, vs_s, vo_s, ft_s;
  logic [9:0] x_d, y_d, x_s, y_s;
`ifdef VGA_FRAME_COUNT_EN
  logic [7:0] fc_d, fc_s;
`endif
  int checks = 0, errors = 0, cyc = 0;
  int nlow, nft, nbad;
  always #5 clk = ~clk;
  vga_sync_gen dut (
    .clk(clk), .reset(rst_d), .p_tick(pt_d), .x(x_d), .y(y_d), .hsync(hs_d),
    .vsync(vs_d), .video_on(vo_d), .frame_tick(ft_d)
`ifdef VGA_FRAME_COUNT_EN
    , .frame_cnt(fc_d)
`endif
  );
  vga_sync_gen #(
    .CLK_DIV(4), .H_DISPLAY(4), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_DISPLAY(2), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
  ) dut_s (
    .clk(clk), .reset(rst_s), .p_tick(pt_s), .x(x_s), .y(y_s), .hsync(hs_s),
    .vsync(vs_s), .video_on(vo_s), .frame_tick(ft_s)
`ifdef VGA_FRAME_COUNT_EN
    , .frame_cnt(fc_s)
`endif
  );
  task automatic to_cyc(input int t);
    repeat (t - cyc) begin
      @(negedge clk);
      #1;
    end
    cyc = t;
  endtask
  task automatic start_d();
    @(negedge clk);
    rst_d = 0;
    cyc = 1;
    #1;
    for (int c = 1; c <= 8; c++) begin
      to_cyc(c);
      `CHK("p_tick_phase", pt_d, (c % 4 == 0))
      if (c == 4) begin
        `CHK("x_before_tick", x_d, 10'd0)
        `CHK("hsync_before_tick", hs_d, 1'b1)
      end
      if (c == 5) `CHK("x_after_tick", x_d, 10'd1)
    end
  endtask
  initial begin
    @(negedge clk);
    #1;
    `CHK("rst_x", x_d, 10'd0)
    `CHK("rst_y", y_d, 10'd0)
    `CHK("rst_hsync", hs_d, 1'b1)
    `CHK("rst_vsync", vs_d, 1'b1)
    `CHK("rst_p_tick", pt_d, 1'b0)
    `CHK("rst_frame_tick", ft_d, 1'b0)
    `CHK("rst_video_on", vo_d, 1'b1)
`ifdef VGA_FRAME_COUNT_EN
    `CHK("rst_frame_cnt", fc_d, 8'd0)
`endif
    start_d();
    to_cyc(2557);
    `CHK("x639", x_d, 10'd639)
    `CHK("vo_639_0", vo_d, 1'b1)
    to_cyc(2561);
    `CHK("vo_640_0", vo_d, 1'b0)
    to_cyc(2621);
    `CHK("hsync_655", hs_d, 1'b1)
    to_cyc(2625);
    `CHK("x656", x_d, 10'd656)
    `CHK("hsync_656", hs_d, 1'b0)
    to_cyc(3008);
    `CHK("hsync_751", hs_d, 1'b0)
    to_cyc(3009);
    `CHK("hsync_752", hs_d, 1'b1)
    to_cyc(3197);
    `CHK("x799", x_d, 10'd799)
    `CHK("y_line0", y_d, 10'd0)
    to_cyc(3200);
    `CHK("p_tick_799", pt_d, 1'b1)
    `CHK("ft_not_frame_end", ft_d, 1'b0)
    to_cyc(3201);
    `CHK("x_wrap", x_d, 10'd0)
    `CHK("y_incr", y_d, 10'd1)
    nlow = 0;
    nbad = 0;
    for (int c = 3201; c <= 6400; c++) begin
      to_cyc(c);
      if (!hs_d) nlow++;
      if (x_d !== 10'((c - 1) / 4 % 800) || y_d !== 10'd1) nbad++;
    end
    `CHK("hsync_low_clks", nlow, 384)
    `CHK("line_xy_bad", nbad, 0)
    to_cyc(9202);
    `CHK("pre_rst_x", x_d, 10'd700)
    `CHK("pre_rst_y", y_d, 10'd2)
    `CHK("pre_rst_hsync", hs_d, 1'b0)
    rst_d = 1;
    #1;
    `CHK("mid_rst_x", x_d, 10'd0)
    `CHK("mid_rst_y", y_d, 10'd0)
    `CHK("mid_rst_hsync", hs_d, 1'b1)
    `CHK("mid_rst_p_tick", pt_d, 1'b0)
    start_d();
    @(negedge clk);
    rst_s = 0;
    cyc = 1;
    #1;
    `CHK("s_rst_vsync", vs_s, 1'b1)
    to_cyc(17);
    `CHK("s_vo_4_0", vo_s, 1'b0)
    to_cyc(53);
    `CHK("s_vo_3_1", vo_s, 1'b1)
    to_cyc(81);
    `CHK("s_y2", y_s, 10'd2)
    `CHK("s_vo_0_2", vo_s, 1'b0)
    to_cyc(117);
    `CHK("s_vsync_y2", vs_s, 1'b1)
    to_cyc(121);
    `CHK("s_vsync_y3", vs_s, 1'b0)
    to_cyc(197);
    `CHK("s_vsync_y4", vs_s, 1'b0)
    to_cyc(201);
    `CHK("s_vsync_y5", vs_s, 1'b1)
    to_cyc(239);
    `CHK("s_ft_early", ft_s, 1'b0)
    to_cyc(240);
    `CHK("s_ft", ft_s, 1'b1)
    `CHK("s_ft_x", x_s, 10'd9)
    `CHK("s_ft_y", y_s, 10'd5)
    to_cyc(241);
    `CHK("s_ft_width", ft_s, 1'b0)
    `CHK("s_wrap_xy", {x_s, y_s}, 20'd0)
    nlow = 0;
    nft = 0;
    for (int c = 241; c <= 720; c++) begin
      to_cyc(c);
      if (!vs_s) nlow++;
      if (ft_s) nft++;
    end
    `CHK("s_vsync_low_clks", nlow, 160)
    `CHK("s_ft_count", nft, 2)
    to_cyc(869);
    `CHK("s_pre_rst_xy", {x_s, y_s}, {10'd7, 10'd3})
    `CHK("s_pre_rst_syncs", {hs_s, vs_s}, 2'b00)
    rst_s = 1;
    #1;
    `CHK("s_mid_rst_xy", {x_s, y_s}, 20'd0)
    `CHK("s_mid_rst_syncs", {hs_s, vs_s}, 2'b11)
    @(negedge clk);
    rst_s = 0;
    cyc = 1;
    #1;
    to_cyc(3);
    `CHK("s_restart_c3", pt_s, 1'b0)
    to_cyc(4);
    `CHK("s_restart_c4", pt_s, 1'b1)
`ifdef VGA_FRAME_COUNT_EN
    `CHK("s_fc_start", fc_s, 8'd0)
    to_cyc(255 * 240 + 1);
    `CHK("s_fc_255", fc_s, 8'd255)
    to_cyc(256 * 240);
    `CHK("s_fc_256th_tick", ft_s, 1'b1)
    to_cyc(256 * 240 + 1);
    `CHK("s_fc_wrap", fc_s, 8'd0)
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
